// File: rtl/dpp_table_arbiter.sv
// Dining-philosophers table controller: arbitrates NUM_PHILO philosophers over
// NUM_PHILO shared forks with round-robin fairness and starvation priority.
module dpp_table_arbiter #(
  parameter int NUM_PHILO    = 5,
  parameter int STARVE_LIMIT = 16,
  parameter int WAIT_W       = $clog2(STARVE_LIMIT + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_PHILO-1:0] hungry_i,
  input  logic [NUM_PHILO-1:0] done_i,
  input  logic                 clear_err_i,
  output logic [NUM_PHILO-1:0] eat_o,
  output logic [NUM_PHILO-1:0] eating_o,
  output logic [NUM_PHILO-1:0] fork_busy_o,
  output logic [NUM_PHILO-1:0] starving_o,
  output logic                 protocol_err_o
);

  localparam int unsigned          NP    = NUM_PHILO;
  localparam int                   PTR_W = $clog2(NUM_PHILO);
  localparam logic [NUM_PHILO-1:0] ONE   = NUM_PHILO'(1);

  typedef enum logic [1:0] {
    HUNGRY   = 2'd0,
    THINKING = 2'd1,
    EATING   = 2'd2
  } phil_state_e;

  phil_state_e          r_state   [NUM_PHILO];
  phil_state_e          w_state_nx[NUM_PHILO];
  logic [WAIT_W-1:0]    r_wait    [NUM_PHILO];
  logic [WAIT_W-1:0]    w_wait_nx [NUM_PHILO];
  logic [PTR_W-1:0]     r_rr, w_rr_nx;
  logic [NUM_PHILO-1:0] r_eat, w_eat_nx;
  logic                 r_err, w_err_nx;

  logic [NUM_PHILO-1:0] w_hungry, w_eating, w_starving;
  logic [NUM_PHILO-1:0] w_fork_busy, w_reserved;
  logic [NUM_PHILO-1:0] w_cand_hi, w_cand_lo, w_pick, w_grant;
  logic [PTR_W-1:0]     w_win;
  logic                 w_win_valid;

  // Left fork i plus right fork (i+1) mod N.
  function automatic logic [NUM_PHILO-1:0] fork_mask(input int unsigned i);
    fork_mask = (ONE << i) | ((i == NP - 1) ? ONE : (ONE << (i + 1)));
  endfunction

  always_comb begin
    w_hungry    = '0;
    w_eating    = '0;
    w_starving  = '0;
    w_fork_busy = '0;
    w_reserved  = '0;
    w_cand_hi   = '0;
    w_cand_lo   = '0;
    for (int unsigned i = 0; i < NP; i++) begin
      w_hungry[i]   = (r_state[i] == HUNGRY);
      w_eating[i]   = (r_state[i] == EATING);
      w_starving[i] = w_hungry[i] && (r_wait[i] == WAIT_W'(STARVE_LIMIT));
      if (w_eating[i])   w_fork_busy = w_fork_busy | fork_mask(i);
      if (w_starving[i]) w_reserved  = w_reserved  | fork_mask(i);
    end
    // Starving philosophers ignore reservations so adjacent starvers cannot deadlock.
    for (int unsigned i = 0; i < NP; i++) begin
      w_cand_hi[i] = w_starving[i] && ((fork_mask(i) & w_fork_busy) == '0);
      w_cand_lo[i] = w_hungry[i] && !w_starving[i] &&
                     ((fork_mask(i) & (w_fork_busy | w_reserved)) == '0);
    end
  end

  always_comb begin
    int unsigned v_idx;
    v_idx       = 0;
    w_win       = '0;
    w_win_valid = 1'b0;
    w_pick      = (|w_cand_hi) ? w_cand_hi : w_cand_lo;
    for (int unsigned k = 0; k < NP; k++) begin
      v_idx = int'(r_rr) + k;
      if (v_idx >= NP) v_idx = v_idx - NP;
      if (!w_win_valid && w_pick[v_idx]) begin
        w_win_valid = 1'b1;
        w_win       = PTR_W'(v_idx);
      end
    end
    w_grant = w_win_valid ? (ONE << w_win) : '0;
  end

  always_comb begin
    w_state_nx = r_state;
    w_wait_nx  = r_wait;
    w_rr_nx    = r_rr;
    w_eat_nx   = w_grant;
    w_err_nx   = r_err & ~clear_err_i;
    if (w_win_valid)
      w_rr_nx = (w_win == PTR_W'(NP - 1)) ? '0 : w_win + 1'b1;
    for (int unsigned i = 0; i < NP; i++) begin
      // done_i shadows hungry_i; illegal pulses only raise the error flag.
      if ((done_i[i] && r_state[i] != EATING) ||
          (hungry_i[i] && !done_i[i] && r_state[i] != THINKING))
        w_err_nx = 1'b1;
      case (r_state[i])
        HUNGRY: begin
          if (w_grant[i]) begin
            w_state_nx[i] = EATING;
            w_wait_nx[i]  = '0;
          end else if (r_wait[i] != WAIT_W'(STARVE_LIMIT)) begin
            w_wait_nx[i]  = r_wait[i] + 1'b1;
          end
        end
        EATING: begin
          if (done_i[i]) w_state_nx[i] = THINKING;
        end
        default: begin
          if (hungry_i[i] && !done_i[i]) begin
            w_state_nx[i] = HUNGRY;
            w_wait_nx[i]  = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NP; i++) begin
        r_state[i] <= THINKING;
        r_wait[i]  <= '0;
      end
      r_rr  <= '0;
      r_eat <= '0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_wait  <= w_wait_nx;
      r_rr    <= w_rr_nx;
      r_eat   <= w_eat_nx;
      r_err   <= w_err_nx;
    end
  end

  assign eat_o          = r_eat;
  assign eating_o       = w_eating;
  assign fork_busy_o    = w_fork_busy;
  assign starving_o     = w_starving;
  assign protocol_err_o = r_err;

endmodule
